// File: rtl/oflow_fe_pkg.sv
// rtl/oflow_fe_pkg.sv - shared widths, bbox/record layouts and FSM states for the oflow feature stage
package oflow_fe_pkg;

  localparam int CM_LEN    = 11;
  localparam int WH_LEN    = 8;
  localparam int COLOR_LEN = 24;
  localparam int DHIST_LEN = 3;
  localparam int FRAME_W   = 1280;
  localparam int FRAME_H   = 720;
  localparam int MAX_BBOX  = 32;

  localparam int BBOX_LEN  = 2*CM_LEN + 2*WH_LEN + 2*COLOR_LEN + DHIST_LEN;
  localparam int ID_W      = $clog2(MAX_BBOX);

  typedef struct packed {
    logic [CM_LEN-1:0]    x_tl;
    logic [CM_LEN-1:0]    y_tl;
    logic [WH_LEN-1:0]    w;
    logic [WH_LEN-1:0]    h;
    logic [COLOR_LEN-1:0] color1;
    logic [COLOR_LEN-1:0] color2;
    logic [DHIST_LEN-1:0] d_hist;
  } bbox_t;

  typedef struct packed {
    logic [CM_LEN-1:0]    x_cm;
    logic [CM_LEN-1:0]    y_cm;
    logic [CM_LEN-1:0]    x_tl;
    logic [CM_LEN-1:0]    y_tl;
    logic [CM_LEN-1:0]    x_br;
    logic [CM_LEN-1:0]    y_br;
    logic [WH_LEN-1:0]    w;
    logic [WH_LEN-1:0]    h;
    logic [COLOR_LEN-1:0] color1;
    logic [COLOR_LEN-1:0] color2;
    logic [DHIST_LEN-1:0] d_hist;
    logic [ID_W-1:0]      id;
    logic                 clipped;
    logic                 last;
  } fe_rec_t;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_OVF} fe_state_e;

endpackage

// File: rtl/oflow_fe_stream_if.sv
// rtl/oflow_fe_stream_if.sv - bbox input stream, feature record output stream and frame status
// OFLOW_FE_AREA_EN adds the area signal.
interface oflow_fe_stream_if;
  import oflow_fe_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [BBOX_LEN-1:0]    in_bbox;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*CM_LEN-1:0]    out_cm;
  logic [4*CM_LEN-1:0]    out_position;
  logic [2*WH_LEN-1:0]    out_wh;
  logic [2*COLOR_LEN-1:0] out_color;
  logic [DHIST_LEN-1:0]   out_dhist;
  logic [ID_W-1:0]        out_bbox_id;
  logic                   out_clipped;
  logic                   out_last;
  logic                   frame_done;
  logic [ID_W:0]          frame_cnt;
  logic                   ovf_err;
`ifdef OFLOW_FE_AREA_EN
  logic [2*WH_LEN-1:0]    area;
`endif

  modport slave (
    input  in_valid, in_bbox, in_last, out_ready,
    output in_ready, out_valid, out_cm, out_position, out_wh, out_color, out_dhist,
           out_bbox_id, out_clipped, out_last, frame_done, frame_cnt, ovf_err
`ifdef OFLOW_FE_AREA_EN
    , output area
`endif
  );

  modport master (
    output in_valid, in_bbox, in_last, out_ready,
    input  in_ready, out_valid, out_cm, out_position, out_wh, out_color, out_dhist,
           out_bbox_id, out_clipped, out_last, frame_done, frame_cnt, ovf_err
`ifdef OFLOW_FE_AREA_EN
    , input area
`endif
  );

endinterface

// File: rtl/oflow_fe_clip.sv
// rtl/oflow_fe_clip.sv - one axis: saturate bottom-right at LIMIT-1 and compute the centre of mass
module oflow_fe_clip
  import oflow_fe_pkg::*;
#(
  parameter int LIMIT = FRAME_W
) (
  input  logic [CM_LEN-1:0] tl,
  input  logic [CM_LEN:0]   sum,
  output logic [CM_LEN-1:0] br,
  output logic [CM_LEN-1:0] cm,
  output logic              clipped
);

  localparam logic [CM_LEN:0] MAX_C = (CM_LEN+1)'(LIMIT - 1);

  logic [CM_LEN:0] cm_sum;

  always_comb begin
    clipped = (sum > MAX_C);
    br      = clipped ? CM_LEN'(MAX_C) : sum[CM_LEN-1:0];
    // The sum keeps its carry so the halved result is exact before truncation.
    cm_sum  = {1'b0, tl} + {1'b0, br};
    cm      = CM_LEN'(cm_sum >> 1);
  end

endmodule

// File: rtl/oflow_fe_stream.sv
// rtl/oflow_fe_stream.sv - bbox feature extraction: 2-stage backpressured pipeline with frame/overflow tracking
// OFLOW_FE_AREA_EN adds the registered w*h area output.
module oflow_fe_stream
  import oflow_fe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  oflow_fe_stream_if.slave bus
);

  bbox_t             in_b;
  logic              accept;
  logic              adv2;
  logic              fwd;
  logic              ovf_done;
  logic              hs_last;

  fe_state_e         state, state_nxt;
  logic [ID_W-1:0]   id_cnt, id_nxt;
  logic              ovf_err_q, ovf_nxt;

  logic              s1_valid;
  bbox_t             s1_b;
  logic [CM_LEN:0]   s1_x_sum, s1_y_sum;
  logic [ID_W-1:0]   s1_id;
  logic              s1_last;

  logic              out_valid_q;
  fe_rec_t           out_rec, rec_nxt;

  logic [CM_LEN-1:0] x_br, y_br, x_cm, y_cm;
  logic              x_clip, y_clip;

  assign in_b         = bbox_t'(bus.in_bbox);
  assign adv2         = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid || adv2;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    id_nxt    = id_cnt;
    ovf_nxt   = ovf_err_q;
    fwd       = 1'b0;
    ovf_done  = 1'b0;
    if (accept) begin
      unique case (state)
        S_IDLE, S_FRAME: begin
          fwd = 1'b1;
          if (state == S_IDLE) ovf_nxt = 1'b0;
          if (bus.in_last) begin
            state_nxt = S_IDLE;
            id_nxt    = '0;
          end else if (id_cnt == ID_W'(MAX_BBOX - 1)) begin
            state_nxt = S_OVF;
          end else begin
            state_nxt = S_FRAME;
            id_nxt    = id_cnt + ID_W'(1);
          end
        end
        S_OVF: begin
          // Beats past the per-frame budget are swallowed until the frame closes.
          ovf_nxt = 1'b1;
          if (bus.in_last) begin
            state_nxt = S_IDLE;
            id_nxt    = '0;
            ovf_done  = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      id_cnt      <= '0;
      ovf_err_q   <= 1'b0;
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_rec     <= '0;
    end else begin
      state     <= state_nxt;
      id_cnt    <= id_nxt;
      ovf_err_q <= ovf_nxt;
      if (bus.in_ready) s1_valid <= fwd;
      if (adv2) begin
        out_valid_q <= s1_valid;
        if (s1_valid) out_rec <= rec_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_ready) begin
      s1_b     <= in_b;
      s1_x_sum <= {1'b0, in_b.x_tl} + (CM_LEN+1)'(in_b.w);
      s1_y_sum <= {1'b0, in_b.y_tl} + (CM_LEN+1)'(in_b.h);
      s1_id    <= id_cnt;
      s1_last  <= bus.in_last;
    end
  end

  oflow_fe_clip #(.LIMIT(FRAME_W)) u_clip_x (
    .tl      (s1_b.x_tl),
    .sum     (s1_x_sum),
    .br      (x_br),
    .cm      (x_cm),
    .clipped (x_clip)
  );

  oflow_fe_clip #(.LIMIT(FRAME_H)) u_clip_y (
    .tl      (s1_b.y_tl),
    .sum     (s1_y_sum),
    .br      (y_br),
    .cm      (y_cm),
    .clipped (y_clip)
  );

  always_comb begin
    rec_nxt         = '0;
    rec_nxt.x_cm    = x_cm;
    rec_nxt.y_cm    = y_cm;
    rec_nxt.x_tl    = s1_b.x_tl;
    rec_nxt.y_tl    = s1_b.y_tl;
    rec_nxt.x_br    = x_br;
    rec_nxt.y_br    = y_br;
    rec_nxt.w       = s1_b.w;
    rec_nxt.h       = s1_b.h;
    rec_nxt.color1  = s1_b.color1;
    rec_nxt.color2  = s1_b.color2;
    rec_nxt.d_hist  = s1_b.d_hist;
    rec_nxt.id      = s1_id;
    rec_nxt.clipped = x_clip || y_clip;
    rec_nxt.last    = s1_last;
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_cm       = {out_rec.x_cm, out_rec.y_cm};
  assign bus.out_position = {out_rec.x_tl, out_rec.y_tl, out_rec.x_br, out_rec.y_br};
  assign bus.out_wh       = {out_rec.w, out_rec.h};
  assign bus.out_color    = {out_rec.color1, out_rec.color2};
  assign bus.out_dhist    = out_rec.d_hist;
  assign bus.out_bbox_id  = out_rec.id;
  assign bus.out_clipped  = out_rec.clipped;
  assign bus.out_last     = out_rec.last;
  assign bus.ovf_err      = ovf_err_q;

  // Gated by reset so a frame torn down mid-flight never reports completion.
  assign hs_last        = out_valid_q && bus.out_ready && out_rec.last;
  assign bus.frame_done = !reset && (hs_last || ovf_done);
  assign bus.frame_cnt  = reset    ? '0 :
                          ovf_done ? (ID_W+1)'(MAX_BBOX) :
                          hs_last  ? ({1'b0, out_rec.id} + (ID_W+1)'(1)) : '0;

`ifdef OFLOW_FE_AREA_EN
  logic [2*WH_LEN-1:0] area_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      area_q <= '0;
    end else if (adv2 && s1_valid) begin
      area_q <= (2*WH_LEN)'(s1_b.w) * (2*WH_LEN)'(s1_b.h);
    end
  end

  assign bus.area = area_q;
`endif

endmodule
